// File: rtl/sram_port.sv
// sram_port: arbitrates the CPU byte port and the video pixel fetcher onto
// the external 8-bit asynchronous SRAM, sequencing CE/OE/WE with WAIT strobe
// cycles. Every output is a register; the next-state process computes the
// value each register takes at the coming edge.
module sram_port #(
  parameter int WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,
  output logic        busy,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_data_o,
  output logic        sram_data_oe,
  input  logic [7:0]  sram_data_i,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WSETUP = 3'd2,
    WPULSE = 3'd3,
    WHOLD  = 3'd4
  } state_t;

  // Terminal value of the strobe counter: the strobe lasts WAIT cycles.
  localparam logic [3:0] LAST = 4'(WAIT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        owner_vid, owner_vid_nx;
  logic        last_vid, last_vid_nx;
  logic        grant_vid, grant_cpu;

  logic [20:0] addr_nx;
  logic [7:0]  data_o_nx;
  logic        data_oe_nx;
  logic        ce_nx, oe_nx, we_nx;
  logic [7:0]  cpu_rdata_nx, vid_rdata_nx;
  logic        cpu_done_nx, vid_ack_nx, busy_nx;

  // Next-state, arbitration and next output values.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    owner_vid_nx = owner_vid;
    last_vid_nx  = last_vid;
    addr_nx      = sram_addr;
    data_o_nx    = sram_data_o;
    data_oe_nx   = sram_data_oe;
    ce_nx        = sram_ce;
    oe_nx        = sram_oe;
    we_nx        = sram_we;
    cpu_rdata_nx = cpu_rdata;
    vid_rdata_nx = vid_rdata;
    cpu_done_nx  = 1'b0;
    vid_ack_nx   = 1'b0;
    grant_vid    = 1'b0;
    grant_cpu    = 1'b0;

    unique case (state)
      IDLE: begin
        // The cycle carrying a done/ack pulse never grants, so a requester
        // can drop its level request before it would be served twice.
        if (!cpu_done && !vid_ack) begin
          // Video has priority unless it took the previous slot.
          grant_vid = vid_req && (!cpu_req || !last_vid);
          grant_cpu = cpu_req && !grant_vid;
          if (grant_vid) begin
            owner_vid_nx = 1'b1;
            last_vid_nx  = 1'b1;
            addr_nx      = vid_addr;
            ce_nx        = 1'b0;
            oe_nx        = 1'b0;
            cnt_nx       = 4'd0;
            state_nx     = RD;
          end else if (grant_cpu) begin
            owner_vid_nx = 1'b0;
            last_vid_nx  = 1'b0;
            addr_nx      = cpu_addr;
            ce_nx        = 1'b0;
            cnt_nx       = 4'd0;
            if (cpu_we) begin
              data_o_nx  = cpu_wdata;
              data_oe_nx = 1'b1;
              state_nx   = WSETUP;
            end else begin
              oe_nx    = 1'b0;
              state_nx = RD;
            end
          end
        end
      end

      RD: begin
        if (cnt == LAST) begin
          // Last OE-low cycle: capture the pad and release the chip.
          ce_nx    = 1'b1;
          oe_nx    = 1'b1;
          state_nx = IDLE;
          if (owner_vid) begin
            vid_rdata_nx = sram_data_i;
            vid_ack_nx   = 1'b1;
          end else begin
            cpu_rdata_nx = sram_data_i;
            cpu_done_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end

      WSETUP: begin
        // Address and data have settled for one cycle; start the WE pulse.
        we_nx    = 1'b0;
        cnt_nx   = 4'd0;
        state_nx = WPULSE;
      end

      WPULSE: begin
        if (cnt == LAST) begin
          we_nx    = 1'b1;
          state_nx = WHOLD;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end

      WHOLD: begin
        // Data was held one cycle past the WE rising edge; finish now.
        ce_nx       = 1'b1;
        data_oe_nx  = 1'b0;
        cpu_done_nx = 1'b1;
        state_nx    = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Busy covers the whole access including its completion cycle.
    busy_nx = (state_nx != IDLE) || cpu_done_nx || vid_ack_nx;
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      owner_vid    <= 1'b0;
      last_vid     <= 1'b0;
      sram_addr    <= 21'd0;
      sram_data_o  <= 8'd0;
      sram_data_oe <= 1'b0;
      sram_ce      <= 1'b1;
      sram_oe      <= 1'b1;
      sram_we      <= 1'b1;
      cpu_rdata    <= 8'd0;
      vid_rdata    <= 8'd0;
      cpu_done     <= 1'b0;
      vid_ack      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      owner_vid    <= owner_vid_nx;
      last_vid     <= last_vid_nx;
      sram_addr    <= addr_nx;
      sram_data_o  <= data_o_nx;
      sram_data_oe <= data_oe_nx;
      sram_ce      <= ce_nx;
      sram_oe      <= oe_nx;
      sram_we      <= we_nx;
      cpu_rdata    <= cpu_rdata_nx;
      vid_rdata    <= vid_rdata_nx;
      cpu_done     <= cpu_done_nx;
      vid_ack      <= vid_ack_nx;
      busy         <= busy_nx;
    end
  end

endmodule

// File: tb/tb_sram_port.sv
// tb_sram_port: SRAM device model on the pins, a transaction-level reference
// of the access timeline checked every negedge, directed scenarios with
// literal expectations, and a randomized requester phase.
module tb_sram_port;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        vid_req;
  logic [20:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_ack;
  logic        busy;
  logic [20:0] sram_addr;
  logic [7:0]  sram_data_o;
  logic        sram_data_oe;
  logic [7:0]  sram_data_i;
  logic        sram_ce, sram_oe, sram_we;

  sram_port #(.WAIT(W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .busy(busy), .sram_addr(sram_addr), .sram_data_o(sram_data_o),
    .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i),
    .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Device memory (written by the pins) and reference memory (written by the model).
  logic [7:0] dev_mem [0:2097151];
  logic [7:0] ref_mem [0:2097151];

  function automatic logic [7:0] init_val(input int a);
    return 8'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  function automatic logic [20:0] rand_addr();
    logic [20:0] base;
    base = ($urandom_range(0, 1) == 1) ? 21'h1FFFC0 : 21'h000000;
    return base | 21'($urandom_range(0, 63));
  endfunction

  // Asynchronous SRAM read path: drives data while CE and OE are both low.
  assign sram_data_i = (!sram_ce && !sram_oe) ? dev_mem[sram_addr] : 8'hEE;

  // SRAM write: committed on the WE rising edge while CE is still low.
  logic prev_we = 1'b1;
  always @(negedge clk) begin
    if (prev_we == 1'b0 && sram_we == 1'b1 && sram_ce == 1'b0)
      dev_mem[sram_addr] <= sram_data_o;
    prev_we <= sram_we;
  end

  // Reference model: phase = periods since the grant edge (0 = idle).
  int          phase = 0;
  bit          m_wr = 1'b0, m_vid = 1'b0, m_last_vid = 1'b0;
  logic [20:0] m_addr = 21'd0;
  logic [7:0]  m_wdata = 8'd0;
  logic [7:0]  e_cpu_rd = 8'd0, e_vid_rd = 8'd0;

  always @(negedge clk) begin
    int  plen;
    bit  act, e_ce, e_oe, e_we, e_doe, e_done, e_ack;
    plen   = m_wr ? W + 3 : W + 1;
    act    = (phase >= 1);
    e_ce   = !(act && phase <= (m_wr ? W + 2 : W));
    e_oe   = !(act && !m_wr && phase <= W);
    e_we   = !(act && m_wr && phase >= 2 && phase <= W + 1);
    e_doe  = act && m_wr && phase <= W + 2;
    e_done = act && phase == plen && !m_vid;
    e_ack  = act && phase == plen && m_vid;
    chk("m_ce", 32'(sram_ce), 32'(e_ce));
    chk("m_oe", 32'(sram_oe), 32'(e_oe));
    chk("m_we", 32'(sram_we), 32'(e_we));
    chk("m_data_oe", 32'(sram_data_oe), 32'(e_doe));
    chk("m_busy", 32'(busy), 32'(act));
    chk("m_cpu_done", 32'(cpu_done), 32'(e_done));
    chk("m_vid_ack", 32'(vid_ack), 32'(e_ack));
    chk("m_cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rd));
    chk("m_vid_rdata", 32'(vid_rdata), 32'(e_vid_rd));
    if (!e_ce) chk("m_addr", 32'(sram_addr), 32'(m_addr));
    if (e_doe) chk("m_data_o", 32'(sram_data_o), 32'(m_wdata));

    // Advance to the period after the coming edge, using the inputs it samples.
    if (reset) begin
      phase = 0; m_last_vid = 1'b0; m_wr = 1'b0; m_vid = 1'b0;
      e_cpu_rd = 8'd0; e_vid_rd = 8'd0; m_addr = 21'd0;
    end else if (phase == 0) begin
      if (vid_req && (!cpu_req || !m_last_vid)) begin
        phase = 1; m_vid = 1'b1; m_wr = 1'b0; m_addr = vid_addr; m_last_vid = 1'b1;
      end else if (cpu_req) begin
        phase = 1; m_vid = 1'b0; m_wr = cpu_we; m_addr = cpu_addr;
        if (cpu_we) m_wdata = cpu_wdata;
        m_last_vid = 1'b0;
      end
    end else if (phase == plen) begin
      phase = 0;
    end else begin
      phase++;
      if (m_wr && phase == W + 2) ref_mem[m_addr] = m_wdata;
      if (!m_wr && phase == plen) begin
        if (m_vid) e_vid_rd = ref_mem[m_addr];
        else       e_cpu_rd = ref_mem[m_addr];
      end
    end
  end

  // One CPU access, called just after a posedge; samples pins after each edge.
  task automatic run_cpu(input logic we, input logic [20:0] a, input logic [7:0] d,
                         output int lat, output int oe_lo, output int we_lo,
                         output int doe_hi, output bit inside_ok, output bit addr_ok);
    bit prev_doe, prev_w, got;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0; oe_lo = 0; we_lo = 0; doe_hi = 0; inside_ok = 1'b1; addr_ok = 1'b1;
    prev_doe = 1'b0; prev_w = 1'b1; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (!sram_oe) oe_lo++;
      if (!sram_we) we_lo++;
      if (sram_data_oe) doe_hi++;
      if (!sram_we && !sram_data_oe) inside_ok = 1'b0;
      if (sram_data_oe && !prev_doe && !sram_we) inside_ok = 1'b0;
      if (!sram_data_oe && prev_doe && !prev_w) inside_ok = 1'b0;
      if (!sram_ce && sram_addr !== a) addr_ok = 1'b0;
      prev_doe = sram_data_oe; prev_w = sram_we;
      if (cpu_done) got = 1'b1;
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, oe_lo, we_lo, doe_hi;
    bit inside_ok, addr_ok, found;
    logic [7:0] ev [$];
    int evt [$];
    int t;

    for (int i = 0; i < 2097152; i++) begin
      dev_mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    dev_mem[21'h012345] = 8'hA5;
    ref_mem[21'h012345] = 8'hA5;

    // Reset held two cycles with a CPU request pending.
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h012345; cpu_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = 21'd0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_ce", 32'(sram_ce), 32'd1);
      chk("rst_oe", 32'(sram_oe), 32'd1);
      chk("rst_we", 32'(sram_we), 32'd1);
      chk("rst_data_oe", 32'(sram_data_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_data_o", 32'(sram_data_o), 32'd0);
      chk("rst_rdata", 32'({cpu_rdata, vid_rdata}), 32'd0);
      chk("rst_pulses", 32'({cpu_done, vid_ack, busy}), 32'd0);
    end
    reset = 1'b0; cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // CPU read of 0xA5 at 0x012345.
    run_cpu(1'b0, 21'h012345, 8'h00, lat, oe_lo, we_lo, doe_hi, inside_ok, addr_ok);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_oe_cycles", 32'(oe_lo), 32'd3);
    chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
    chk("rd_addr_stable", 32'(addr_ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // CPU write of 0x3C to the top address.
    run_cpu(1'b1, 21'h1FFFFF, 8'h3C, lat, oe_lo, we_lo, doe_hi, inside_ok, addr_ok);
    chk("wr_latency", 32'(lat), 32'd6);
    chk("wr_doe_cycles", 32'(doe_hi), 32'd5);
    chk("wr_we_cycles", 32'(we_lo), 32'd3);
    chk("wr_we_inside", 32'(inside_ok), 32'd1);
    chk("wr_addr_stable", 32'(addr_ok), 32'd1);
    @(posedge clk); #1;
    chk("wr_mem", 32'(dev_mem[21'h1FFFFF]), 32'h3C);
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous requests held high: order V, C, V, C, five cycles apart.
    cpu_we = 1'b0; cpu_addr = 21'h000010; vid_addr = 21'h000020;
    cpu_req = 1'b1; vid_req = 1'b1;
    t = 0;
    for (int i = 0; i < 60 && ev.size() < 4; i++) begin
      @(posedge clk); #1;
      t++;
      if (vid_ack)  begin ev.push_back(8'h56); evt.push_back(t); end
      if (cpu_done) begin ev.push_back(8'h43); evt.push_back(t); end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    chk("arb_count", 32'(ev.size()), 32'd4);
    if (ev.size() == 4) begin
      chk("arb_order0", 32'(ev[0]), 32'h56);
      chk("arb_order1", 32'(ev[1]), 32'h43);
      chk("arb_order2", 32'(ev[2]), 32'h56);
      chk("arb_order3", 32'(ev[3]), 32'h43);
      chk("arb_first", 32'(evt[0]), 32'd4);
      for (int i = 0; i < 3; i++) chk("arb_gap", 32'(evt[i+1] - evt[i]), 32'd5);
    end
    repeat (3) @(posedge clk);
    #1;

    // Saturated video with ten CPU reads.
    vid_req = 1'b1; vid_addr = rand_addr();
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_cpu(1'b0, rand_addr(), 8'h00, lat, oe_lo, we_lo, doe_hi, inside_ok, addr_ok);
      chk("sat_latency_le10", 32'(lat <= 10), 32'd1);
    end
    vid_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset during the WE pulse abandons the write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h000100; cpu_wdata = 8'h77;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (!sram_we) found = 1'b1;
    end
    chk("rmw_reached_wpulse", 32'(found), 32'd1);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("rmw_we", 32'(sram_we), 32'd1);
    chk("rmw_ce", 32'(sram_ce), 32'd1);
    chk("rmw_data_oe", 32'(sram_data_oe), 32'd0);
    chk("rmw_done", 32'(cpu_done), 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rmw_no_done", 32'(cpu_done), 32'd0);
    end
    run_cpu(1'b0, 21'h012345, 8'h00, lat, oe_lo, we_lo, doe_hi, inside_ok, addr_ok);
    chk("rmw_read_latency", 32'(lat), 32'd4);
    chk("rmw_read_data", 32'(cpu_rdata), 32'hA5);
    repeat (2) @(posedge clk);
    #1;

    // Randomized requesters, withdrawals and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if (cpu_done && cpu_req) cpu_req = 1'b0;
      else if (cpu_req && $urandom_range(0, 63) == 0) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
      end
      if (vid_ack && vid_req) vid_req = 1'b0;
      else if (vid_req && $urandom_range(0, 63) == 0) vid_req = 1'b0;
      else if (!vid_req && $urandom_range(0, 2) == 0) begin
        vid_req = 1'b1; vid_addr = rand_addr();
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0; reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
